dds_phase_accumulator: RTL

Phase-accumulator front end of the DDS chain, placed directly upstream of the input register stage. It holds a programmable frequency tuning word (FTW) and a per-sample FTW increment (DELTA), which supports single-tone and linear-chirp generation. It emits the truncated phase sample-by-sample for a programmed burst length or in free-run mode. Its registered output drives the input register stage that feeds the phase-to-amplitude path.

---
 rtl/dds_phase_accumulator.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dds_phase_accumulator.sv
// Phase-accumulator front end of the DDS chain. Supports single-tone and linear-chirp bursts of a
// programmed length, or free-running, and emits the truncated accumulator phase one sample per cycle.
module dds_phase_accumulator #(
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 12,
   parameter int STEPS_W = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               LOAD,
   input  logic [PHASE_W-1:0] FTW_IN,
   input  logic [PHASE_W-1:0] DELTA_IN,
   input  logic [STEPS_W-1:0] STEPS_IN,
   input  logic               START,
   input  logic               STOP,
   output logic [OUT_W-1:0]   PHASE_OUT,
   output logic               VALID,
   output logic               BUSY,
   output logic               DONE
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t state_q, state_d;

   logic        [PHASE_W-1:0] ftw_reg;
   logic signed [PHASE_W-1:0] delta_reg;
   logic        [STEPS_W-1:0] steps_reg;

   logic        [PHASE_W-1:0] acc_p0;
   logic        [PHASE_W-1:0] ftw_cur_p0;
   logic        [STEPS_W-1:0] cnt_p0;

   logic        [OUT_W-1:0]   phase_p1;
   logic                      vld_p1;
   logic                      done_p1;

   logic                      start_burst;
   logic                      emit_sample;
   logic                      last_sample;
   logic                      busy_c;

   // ---- state register ----
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (START) state_d = S_RUN;
         S_RUN:  if (STOP || cnt_p0 == STEPS_W'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---- output / strobe decode ----
   always_comb begin
      start_burst = 1'b0;
      emit_sample = 1'b0;
      last_sample = 1'b0;
      busy_c      = 1'b0;
      case (state_q)
         S_IDLE: start_burst = START;
         S_RUN: begin
            busy_c      = 1'b1;
            emit_sample = !STOP;
            last_sample = !STOP && (cnt_p0 == STEPS_W'(1));
         end
         default: ;
      endcase
   end

   // ---- stage p0: parameter capture and phase/frequency accumulation ----
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ftw_reg    <= '0;
         delta_reg  <= '0;
         steps_reg  <= '0;
         acc_p0     <= '0;
         ftw_cur_p0 <= '0;
         cnt_p0     <= '0;
      end else begin
         if (state_q == S_IDLE && LOAD) begin
            ftw_reg   <= FTW_IN;
            delta_reg <= $signed(DELTA_IN);
            steps_reg <= STEPS_IN;
         end
         // A coincident LOAD feeds the new values straight into the burst.
         if (start_burst) begin
            acc_p0     <= '0;
            ftw_cur_p0 <= LOAD ? FTW_IN : ftw_reg;
            cnt_p0     <= LOAD ? STEPS_IN : steps_reg;
         end else if (emit_sample) begin
            acc_p0     <= acc_p0 + ftw_cur_p0;
            ftw_cur_p0 <= PHASE_W'($signed(ftw_cur_p0) + delta_reg);
            if (cnt_p0 != '0) cnt_p0 <= cnt_p0 - STEPS_W'(1);
         end
      end
   end

   // ---- stage p1: registered phase sample and strobes ----
   always_ff @(posedge CLK) begin
      if (RESET) begin
         phase_p1 <= '0;
         vld_p1   <= 1'b0;
         done_p1  <= 1'b0;
      end else begin
         vld_p1  <= emit_sample;
         done_p1 <= last_sample;
         if (emit_sample) phase_p1 <= acc_p0[PHASE_W-1 -: OUT_W];
      end
   end

   assign PHASE_OUT = phase_p1;
   assign VALID     = vld_p1;
   assign DONE      = done_p1;
   assign BUSY      = busy_c;

endmodule
